mem_bus_arbiter: RTL

// Shares one memory port between two requesters: M0 = core (Control_Unit memory_read/memory_write/memory_response

---
 rtl/mem_bus_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter for one memory port, with slave timeout and holdoff
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_response,
  output logic                  m0_error,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_response,
  output logic                  m1_error,
  output logic                  s_read,
  output logic                  s_write,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [DATA_WIDTH-1:0] s_write_data,
  input  logic [DATA_WIDTH-1:0] s_read_data,
  input  logic                  s_response
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HOLDOFF} state_t;
  state_t          state;
  logic            last_grant;
  logic [CW-1:0]   cnt;
  logic            req0, req1, g0, g1, granted, timeout, done, sel;
  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign g0      = state == GRANT0;
  assign g1      = state == GRANT1;
  assign granted = g0 | g1;
  // a same-cycle slave response beats timeout expiry
  assign timeout = granted && !s_response && TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done    = granted && (s_response || timeout);
  assign sel     = req1 && (!req0 || !last_grant);
  always_comb begin
    s_write      = g0 ? m0_write : g1 ? m1_write : 1'b0;
    s_read       = g0 ? m0_read & ~m0_write : g1 ? m1_read & ~m1_write : 1'b0;
    s_address    = g0 ? m0_address : g1 ? m1_address : '0;
    s_write_data = g0 ? m0_write_data : g1 ? m1_write_data : '0;
    m0_response  = g0 & done;
    m1_response  = g1 & done;
    m0_error     = g0 & timeout;
    m1_error     = g1 & timeout;
    m0_read_data = (g0 & s_response) ? s_read_data : '0;
    m1_read_data = (g1 & s_response) ? s_read_data : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state      <= sel ? GRANT1 : GRANT0;
          last_grant <= sel;
          cnt        <= '0;
        end
        GRANT0, GRANT1: begin
          state <= done ? HOLDOFF : state;
          cnt   <= done ? '0 : cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
